// File: rtl/data_mem_pkg.sv
// Shared types and defaults for the data-memory responder.
package data_mem_pkg;
  localparam int DEF_DEPTH_WORDS = 256;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int WORD_OFS        = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/data_mem_responder_mem_array.sv
// Single-port synchronous word RAM; read data is registered and held while en is low.
module mem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];

  // No reset: contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: IDLE -> WAIT (WAIT_CYCLES) -> RESP, one request in flight.
// Optional MISALIGN_ERR_EN: misaligned requests skip the array and respond with resp_err.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e        state;
  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          write_q, mis_q, resp_load;

  logic [AW-1:0] req_idx, mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          req_mis, cur_mis, cur_write;
  logic          idle, accept, enter_resp, mem_en, mem_we;
  logic          unused_addr;

  assign req_idx     = req_addr[WORD_OFS +: AW];
  assign unused_addr = ^{req_addr[31:AW+WORD_OFS], req_addr[WORD_OFS-1:0]};

`ifdef MISALIGN_ERR_EN
  assign req_mis = |req_addr[WORD_OFS-1:0];
`else
  assign req_mis = 1'b0;
`endif

  assign idle      = (state == IDLE);
  assign req_ready = idle & ~reset;
  assign accept    = req_valid & req_ready;
  assign busy      = (state != IDLE) | (idle & req_valid);

  // With zero wait states RESP is entered straight from IDLE, so the array
  // must see the live request rather than the latched copy.
  assign cur_write = idle ? req_write : write_q;
  assign cur_mis   = idle ? req_mis   : mis_q;
  assign mem_addr  = idle ? req_idx   : idx_q;
  assign mem_wdata = idle ? req_wdata : wdata_q;

  assign enter_resp = ~reset & ((idle & accept & (WAIT_CYCLES == 0)) |
                                ((state == WAIT) & (cnt == 4'd0)));
  assign mem_en     = enter_resp & ~cur_mis;
  assign mem_we     = mem_en & cur_write;

  mem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_mem (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_load  <= 1'b0;
    end else begin
      resp_valid <= enter_resp;
      resp_err   <= enter_resp & cur_mis;
      resp_load  <= enter_resp & ~cur_write & ~cur_mis;
      case (state)
        IDLE: if (accept) begin
          idx_q   <= req_idx;
          wdata_q <= req_wdata;
          write_q <= req_write;
          mis_q   <= req_mis;
          if (WAIT_CYCLES == 0) state <= RESP;
          else begin
            state <= WAIT;
            cnt   <= CNT_INIT;
          end
        end
        WAIT: if (cnt == 4'd0) state <= RESP;
              else             cnt   <= cnt - 4'd1;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stores and error responses return zero; so does every idle cycle.
  assign resp_rdata = resp_load ? mem_rdata : '0;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: d0 = WAIT_CYCLES 2, d1 = WAIT_CYCLES 0, both 256 words.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        rv [2];
  logic        rw [2];
  logic [31:0] ra [2];
  logic [31:0] rwd[2];
  logic        rdy[2];
  logic        vld[2];
  logic        err[2];
  logic        bsy[2];
  logic [31:0] rd [2];

  data_mem_responder #(.WAIT_CYCLES(2), .DEPTH_WORDS(256)) dut (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_write(rw[0]), .req_addr(ra[0]),
    .req_wdata(rwd[0]), .req_ready(rdy[0]), .resp_valid(vld[0]), .resp_rdata(rd[0]),
    .resp_err(err[0]), .busy(bsy[0]));

  data_mem_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(256)) dut0 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_write(rw[1]), .req_addr(ra[1]),
    .req_wdata(rwd[1]), .req_ready(rdy[1]), .resp_valid(vld[1]), .resp_rdata(rd[1]),
    .resp_err(err[1]), .busy(bsy[1]));

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  bit   prev_resp[2];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare every presented response against the scoreboard head.
  task automatic mon(int d);
    exp_t e;
    int   qs;
    qs = (d == 0) ? q0.size() : q1.size();
    if (vld[d]) begin
      if (qs == 0) chk($sformatf("d%0d_unexpected_resp", d), vld[d], 0);
      else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("d%0d_rdata", d), rd[d], e.rd);
        chk($sformatf("d%0d_err", d), err[d], e.err);
        chk($sformatf("d%0d_latency", d), cyc, e.due);
        chk($sformatf("d%0d_ready_in_resp", d), rdy[d], 0);
      end
      chk($sformatf("d%0d_busy_in_resp", d), bsy[d], 1);
    end else begin
      chk($sformatf("d%0d_rdata_idle", d), rd[d], 0);
      if (qs > 0) begin
        e = (d == 0) ? q0[0] : q1[0];
        if (e.due < cyc) begin
          chk($sformatf("d%0d_resp_missing", d), cyc, e.due);
          if (d == 0) void'(q0.pop_front());
          else        void'(q1.pop_front());
        end
      end
      if (prev_resp[d] && !rv[d]) chk($sformatf("d%0d_busy_after_resp", d), bsy[d], 0);
    end
    prev_resp[d] = vld[d];
  endtask

  initial forever begin
    @(negedge clk);
    if (reset) begin
      prev_resp[0] = 1'b0;
      prev_resp[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) mon(d);
    end
  end

  task automatic do_req(int d, logic w, logic [31:0] a, logic [31:0] wd,
                        logic [31:0] exp_rd, logic exp_err);
    int   n;
    exp_t e;
    n = 0;
    step();
    rv[d] = 1'b1; rw[d] = w; ra[d] = a; rwd[d] = wd;
    #1;
    chk($sformatf("d%0d_busy_same_cycle", d), bsy[d], 1);
    while (!rdy[d] && n < 40) begin step(); #1; n++; end
    if (!rdy[d]) begin
      chk($sformatf("d%0d_accept_timeout", d), rdy[d], 1);
      rv[d] = 1'b0;
      return;
    end
    e.rd = exp_rd; e.err = exp_err; e.due = cyc + 1 + wc(d);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    step();
    rv[d] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q0.size() + q1.size()) != 0 && n < 60) begin step(); n++; end
    chk("drain", q0.size() + q1.size(), 0);
    step(); step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d, want completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int   last_acc;
    int   n;
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0; rw[d] = 1'b0; ra[d] = '0; rwd[d] = '0;
    end
    reset = 1'b1;
    step(); step();
    #1;
    chk("rst_ready_d0", rdy[0], 0);
    chk("rst_ready_d1", rdy[1], 0);
    chk("rst_resp_valid", vld[0], 0);
    chk("rst_rdata", rd[0], 0);
    chk("rst_err", err[0], 0);
    chk("rst_busy", bsy[0], 0);
    step();
    reset = 1'b0;
    #1;
    chk("post_rst_ready_d0", rdy[0], 1);
    chk("post_rst_ready_d1", rdy[1], 1);

    // Store then load, WAIT_CYCLES=2
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    do_req(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    wait_idle();

    // Wrap-around: 0x400 aliases word 0
    do_req(0, 1'b1, 32'h400, 32'h1234, 32'h0, 1'b0);
    do_req(0, 1'b0, 32'h000, 32'h0, 32'h1234, 1'b0);
    wait_idle();

    // Misaligned accesses
`ifdef MISALIGN_ERR_EN
    do_req(0, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
    do_req(0, 1'b1, 32'h12, 32'h0BADF00D, 32'h0, 1'b1);
    do_req(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
`else
    do_req(0, 1'b0, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0);
    do_req(0, 1'b1, 32'h12, 32'h0BADF00D, 32'h0, 1'b0);
    do_req(0, 1'b0, 32'h10, 32'h0, 32'h0BADF00D, 1'b0);
`endif
    wait_idle();

    // Reset during WAIT abandons a store
    do_req(0, 1'b1, 32'h20, 32'h11112222, 32'h0, 1'b0);
    wait_idle();
    step();
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h20; rwd[0] = 32'hAAAA5555;
    #1;
    chk("abort_ready_before", rdy[0], 1);
    step();
    rv[0] = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_ready_in_reset", rdy[0], 0);
    step();
    reset = 1'b0;
    #1;
    chk("abort_ready_after", rdy[0], 1);
    chk("abort_no_resp", vld[0], 0);
    repeat (4) step();
    do_req(0, 1'b0, 32'h20, 32'h0, 32'h11112222, 1'b0);
    wait_idle();

    // WAIT_CYCLES=0: back-to-back loads with req_valid held high
    do_req(1, 1'b1, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0);
    wait_idle();
    step();
    rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 32'h40;
    last_acc = -1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n = 0;
      while (!rdy[1] && n < 20) begin step(); #1; n++; end
      if (!rdy[1]) begin
        chk("b2b_accept_timeout", rdy[1], 1);
        break;
      end
      e.rd = 32'hCAFEF00D; e.err = 1'b0; e.due = cyc + 1;
      q1.push_back(e);
      if (last_acc >= 0) chk("b2b_spacing", cyc + 1 - last_acc, 2);
      last_acc = cyc + 1;
      step();
    end
    rv[1] = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
